// File: rtl/fix_rx_pkg.sv
// fix_rx_pkg: shared types, ASCII constants and helpers for the FIX receive framer
package fix_rx_pkg;
  localparam int FIX_NUM_CH = 4;
  localparam int FIX_TAG_DIGITS = 9;
  localparam int FIX_VAL_BYTES = 16;
  localparam int FIX_TAG_W = 32;
  localparam int CH_W = $clog2(FIX_NUM_CH);
  localparam int VAL_W = 8 * FIX_VAL_BYTES;
  localparam int LEN_W = $clog2(FIX_VAL_BYTES) + 1;
  localparam int ND_W = 4;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ = 8'h3D;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] NINE = 8'h39;
  localparam int CKSUM_TAG = 10;
  typedef enum logic [2:0] {S_IDLE, S_TAG, S_VALUE, S_CKSUM, S_ERR} state_e;
  typedef enum logic [1:0] {E_NONE, E_ABORT, E_BAD_FMT, E_STRAY} err_e;
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic tag_valid;
    logic [FIX_TAG_W-1:0] tag;
    logic val_valid;
    logic [VAL_W-1:0] val;
    logic [LEN_W-1:0] len;
    logic ovf;
    logic eom;
    logic ok;
    err_e err;
  } event_t;
  typedef struct packed {
    state_e st;
    logic [FIX_TAG_W-1:0] tag;
    logic [ND_W-1:0] nd;
    logic [VAL_W-1:0] val;
    logic [LEN_W-1:0] len;
    logic ovf;
    logic [7:0] sum;
    logic [7:0] commit;
    logic [7:0] exp;
    logic [9:0] ck;
  } ctx_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= ZERO && b <= NINE;
  endfunction
  function automatic ctx_t append(input ctx_t c, input logic [7:0] b);
    ctx_t r;
    r = c;
    if (c.len < LEN_W'(FIX_VAL_BYTES)) begin
      r.val = {c.val[VAL_W-9:0], b};
      r.len = c.len + 1'b1;
    end else r.ovf = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/fix_rx_out_stage.sv
// fix_rx_out_stage: one-entry valid/ready register holding a framer event
module fix_rx_out_stage
  import fix_rx_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_valid,
  input  event_t i_data,
  output logic   o_ready,
  output logic   o_valid,
  input  logic   i_ready,
  output event_t o_data
);
  logic r_valid;
  event_t r_data;
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data = r_data;
  // Load a new event (or go empty) whenever the slot is free or being drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      r_data <= i_valid ? i_data : '0;
    end
  end
endmodule

// File: rtl/fix_rx_framer.sv
// fix_rx_framer: multi-channel FIX tag/value framer with checksum verdict
module fix_rx_framer
  import fix_rx_pkg::*;
#(
  parameter int NUM_CH = FIX_NUM_CH,
  parameter int TAG_DIGITS = FIX_TAG_DIGITS,
  parameter int VAL_BYTES = FIX_VAL_BYTES,
  parameter int TAG_W = FIX_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [7:0]                data_i,
  input  logic [$clog2(NUM_CH)-1:0] ch_i,
  input  logic                      sof_i,
  output logic                      in_ready_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [$clog2(NUM_CH)-1:0] ch_o,
  output logic                      tag_valid_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic                      val_valid_o,
  output logic [8*VAL_BYTES-1:0]    val_o,
  output logic [$clog2(VAL_BYTES):0] val_len_o,
  output logic                      val_ovf_o,
  output logic                      eom_o,
  output logic                      cksum_ok_o,
  output logic [1:0]                err_o
);
  ctx_t r_ctx [NUM_CH];
  ctx_t w_cur, w_base, w_nxt;
  event_t w_ev, w_out;
  logic w_evt, w_bad, w_dig, w_acc;
  logic [13:0] w_ck;
  assign w_acc = valid_i && in_ready_o;
  // Advance the addressed channel's context by one byte and form its event
  always_comb begin
    w_cur = r_ctx[ch_i];
    w_base = w_cur;
    if (sof_i) begin
      w_base = '0;
      w_base.st = S_TAG;
    end
    w_nxt = w_base;
    w_nxt.sum = w_base.sum + data_i;
    w_ev = '0;
    w_ev.ch = ch_i;
    w_evt = 1'b0;
    w_bad = 1'b0;
    w_dig = is_digit(data_i);
    w_ck = 14'(w_base.ck) * 14'd10 + 14'(data_i[3:0]);
    case (w_base.st)
      S_IDLE: begin
        w_nxt = w_base;
        w_evt = 1'b1;
        w_ev.err = E_STRAY;
      end
      S_TAG: begin
        if (w_dig && w_base.nd < ND_W'(TAG_DIGITS)) begin
          w_nxt.tag = w_base.tag * FIX_TAG_W'(10) + FIX_TAG_W'(data_i[3:0]);
          w_nxt.nd = w_base.nd + 1'b1;
        end else if (data_i == EQ && w_base.nd != '0) begin
          w_evt = 1'b1;
          w_ev.tag_valid = 1'b1;
          w_ev.tag = w_base.tag;
          w_nxt.nd = '0;
          w_nxt.val = '0;
          w_nxt.len = '0;
          w_nxt.ovf = 1'b0;
          w_nxt.ck = '0;
          w_nxt.exp = w_base.commit;
          w_nxt.st = w_base.tag == FIX_TAG_W'(CKSUM_TAG) ? S_CKSUM : S_VALUE;
        end else w_bad = 1'b1;
      end
      S_VALUE: begin
        if (data_i == SOH) begin
          w_evt = 1'b1;
          w_ev.val_valid = 1'b1;
          w_ev.val = w_base.val;
          w_ev.len = w_base.len;
          w_ev.ovf = w_base.ovf;
          w_nxt.commit = w_nxt.sum;
          w_nxt.st = S_TAG;
          w_nxt.tag = '0;
          w_nxt.nd = '0;
        end else w_nxt = append(w_nxt, data_i);
      end
      S_CKSUM: begin
        if (data_i == SOH) begin
          w_evt = 1'b1;
          w_ev.val_valid = 1'b1;
          w_ev.val = w_base.val;
          w_ev.len = w_base.len;
          w_ev.ovf = w_base.ovf;
          w_ev.eom = 1'b1;
          w_ev.ok = w_base.nd == ND_W'(3) && w_base.ck == {2'b00, w_base.exp};
          w_nxt.st = S_IDLE;
        end else if (w_dig) begin
          w_nxt.ck = w_ck > 14'd1023 ? 10'd1023 : w_ck[9:0];
          w_nxt.nd = w_base.nd + ND_W'(w_base.nd != '1);
          w_nxt = append(w_nxt, data_i);
        end else w_bad = 1'b1;
      end
      default: w_nxt = w_base;
    endcase
    if (w_bad) begin
      w_nxt = w_base;
      w_nxt.st = S_ERR;
      w_evt = 1'b1;
      w_ev.err = E_BAD_FMT;
    end
    if (sof_i && w_cur.st != S_IDLE && !w_bad) begin
      w_evt = 1'b1;
      w_ev.err = E_ABORT;
    end
  end
  // Per-channel context storage, written only for the accepted byte's channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int k = 0; k < NUM_CH; k++) r_ctx[k] <= '0;
    else if (w_acc) r_ctx[ch_i] <= w_nxt;
  end
  fix_rx_out_stage u_out (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_acc && w_evt),
    .i_data  (w_ev),
    .o_ready (in_ready_o),
    .o_valid (out_valid_o),
    .i_ready (out_ready_i),
    .o_data  (w_out)
  );
  assign ch_o = w_out.ch;
  assign tag_valid_o = w_out.tag_valid;
  assign tag_o = w_out.tag;
  assign val_valid_o = w_out.val_valid;
  assign val_o = w_out.val;
  assign val_len_o = w_out.len;
  assign val_ovf_o = w_out.ovf;
  assign eom_o = w_out.eom;
  assign cksum_ok_o = w_out.ok;
  assign err_o = w_out.err;
endmodule
